// File: rtl/landscape_accumulator.sv
// Running-sum stage for the landscape-sampling path. Accumulates a stream of
// unsigned weights, one update per accepted beat, for one pass per start pulse.
// Compile-time option: define LANDSCAPE_ACC_SAT_EN to saturate acc_q on overflow;
// by default acc_q wraps. In both builds ovf is a sticky per-pass carry-out flag.
module landscape_accumulator #(
  parameter int unsigned bit_addr_shi = 19,
  parameter int unsigned bit_w        = 12,
  parameter int unsigned bit_idx      = 10
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    start,
  input  logic [bit_idx-1:0]      len_m1,
  input  logic                    w_valid,
  input  logic [bit_w-1:0]        w_data,
  output logic                    w_ready,
  output logic [bit_addr_shi-1:0] acc_q,
  output logic                    acc_valid,
  output logic [bit_idx-1:0]      acc_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e                  r_state;
  logic [bit_idx-1:0]      r_len;
  logic [bit_idx-1:0]      r_cnt;
  logic [bit_addr_shi-1:0] r_acc;
  logic [bit_idx-1:0]      r_idx;
  logic                    r_acc_valid;
  logic                    r_done;
  logic                    r_ovf;

  logic [bit_addr_shi:0]   w_sum;
  logic                    w_carry;
  logic [bit_addr_shi-1:0] w_next_acc;

  // One extra bit on the adder exposes the carry out of the accumulator MSB.
  always_comb begin
    w_sum   = {1'b0, r_acc} + (bit_addr_shi + 1)'(w_data);
    w_carry = w_sum[bit_addr_shi];
`ifdef LANDSCAPE_ACC_SAT_EN
    // Once at full scale any nonzero weight carries again, so the value sticks.
    w_next_acc = w_carry ? {bit_addr_shi{1'b1}} : w_sum[bit_addr_shi-1:0];
`else
    w_next_acc = w_sum[bit_addr_shi-1:0];
`endif
  end

  // Pass control FSM with all datapath and pulse outputs registered.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= StIdle;
      r_len       <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_acc_valid <= 1'b0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_acc_valid <= 1'b0;
      r_done      <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_len   <= len_m1;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_ovf   <= 1'b0;
            r_state <= StAccum;
          end
        end
        StAccum: begin
          if (w_valid) begin
            r_acc       <= w_next_acc;
            r_idx       <= r_cnt;
            r_cnt       <= r_cnt + 1'b1;
            r_acc_valid <= 1'b1;
            r_ovf       <= r_ovf | w_carry;
            // done is raised here so it is visible during the DONE cycle itself.
            if (r_cnt == r_len) begin
              r_done  <= 1'b1;
              r_state <= StDone;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Handshake and busy decode straight from the state register.
  always_comb begin
    w_ready = (r_state == StAccum);
    busy    = (r_state == StAccum);
  end

  assign acc_q     = r_acc;
  assign acc_valid = r_acc_valid;
  assign acc_idx   = r_idx;
  assign done      = r_done;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_landscape_accumulator.sv
// Scoreboard bench for landscape_accumulator: the driver pushes the expected
// (acc_q, acc_idx) of every beat it issues; a monitor pops on each acc_valid.
module tb_landscape_accumulator;

  localparam int AW = 19;
  localparam int WW = 12;
  localparam int IW = 10;

  logic          clk = 1'b0;
  logic          clr;
  logic          start;
  logic [IW-1:0] len_m1;
  logic          w_valid;
  logic [WW-1:0] w_data;
  logic          w_ready;
  logic [AW-1:0] acc_q;
  logic          acc_valid;
  logic [IW-1:0] acc_idx;
  logic          busy;
  logic          done;
  logic          ovf;

  typedef struct {
    logic [AW-1:0] acc;
    logic [IW-1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cnt = 0;

  landscape_accumulator #(
    .bit_addr_shi(AW),
    .bit_w       (WW),
    .bit_idx     (IW)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .len_m1   (len_m1),
    .w_valid  (w_valid),
    .w_data   (w_data),
    .w_ready  (w_ready),
    .acc_q    (acc_q),
    .acc_valid(acc_valid),
    .acc_idx  (acc_idx),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every acc_valid pulse must match the oldest outstanding beat.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_cnt++;
      if (acc_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("acc_valid_unexpected", 32'(acc_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("acc_q", 32'(acc_q), 32'(e.acc));
          chk("acc_idx", 32'(acc_idx), 32'(e.idx));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // All driver tasks start and end at a negedge.
  task automatic beat(input logic [WW-1:0] d, input int ea, input int ei);
    w_valid = 1'b1;
    w_data  = d;
    exp_q.push_back('{acc: AW'(ea), idx: IW'(ei)});
    @(negedge clk);
    w_valid = 1'b0;
    w_data  = '0;
  endtask

  task automatic gap();
    w_valid = 1'b0;
    w_data  = WW'($urandom);
    @(negedge clk);
    w_data  = '0;
  endtask

  task automatic do_start(input int len);
    start  = 1'b1;
    len_m1 = IW'(len);
    @(negedge clk);
    start  = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("w_ready_after_start", 32'(w_ready), 32'd1);
  endtask

  // Called at the negedge right after the last beat's edge (the DONE cycle).
  task automatic end_pass(input string tag, input int ea, input int ei, input int eovf,
                          input int d0);
    chk({tag, "_done_pulse"}, 32'(done), 32'd1);
    chk({tag, "_w_ready_done"}, 32'(w_ready), 32'd0);
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, "_done_low"}, 32'(done), 32'd0);
    chk({tag, "_acc_held"}, 32'(acc_q), 32'(ea));
    chk({tag, "_idx_held"}, 32'(acc_idx), 32'(ei));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
    chk({tag, "_done_count"}, 32'(done_cnt), 32'(d0 + 1));
  endtask

  initial begin
    int d0;
    int m;
    clr     = 1'b1;
    start   = 1'b0;
    len_m1  = '0;
    w_valid = 1'b0;
    w_data  = '0;

    // Reset then idle.
    @(negedge clk);
    @(negedge clk);
    chk("rst_acc_q", 32'(acc_q), 32'd0);
    chk("rst_acc_idx", 32'(acc_idx), 32'd0);
    chk("rst_acc_valid", 32'(acc_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_w_ready", 32'(w_ready), 32'd0);
    clr = 1'b0;

    // w_valid in IDLE must be ignored.
    w_valid = 1'b1;
    w_data  = 12'd33;
    @(negedge clk);
    @(negedge clk);
    w_valid = 1'b0;
    chk("idle_acc_q", 32'(acc_q), 32'd0);

    // Basic pass.
    d0 = done_cnt;
    do_start(3);
    beat(12'd5, 5, 0);
    beat(12'd7, 12, 1);
    beat(12'd0, 12, 2);
    beat(12'd12, 24, 3);
    end_pass("basic", 24, 3, 0, d0);

    // Back-pressure.
    d0 = done_cnt;
    do_start(2);
    beat(12'd1, 1, 0);
    gap();
    gap();
    beat(12'd2, 3, 1);
    beat(12'd3, 6, 2);
    end_pass("bp", 6, 2, 0, d0);

    // start during ACCUM must be ignored.
    d0 = done_cnt;
    do_start(5);
    beat(12'd1, 1, 0);
    start  = 1'b1;
    len_m1 = '0;
    beat(12'd2, 3, 1);
    start  = 1'b0;
    beat(12'd3, 6, 2);
    beat(12'd4, 10, 3);
    beat(12'd5, 15, 4);
    beat(12'd6, 21, 5);
    end_pass("start_ign", 21, 5, 0, d0);

    // Overflow: 131 beats of 4095.
    d0 = done_cnt;
    m  = 0;
    do_start(130);
    for (int i = 0; i < 131; i++) begin
`ifdef LANDSCAPE_ACC_SAT_EN
      m = (m + 4095 > 524287) ? 524287 : m + 4095;
`else
      m = (m + 4095) % 524288;
`endif
      beat(12'd4095, m, i);
    end
`ifdef LANDSCAPE_ACC_SAT_EN
    end_pass("ovf", 524287, 130, 1, d0);
`else
    end_pass("ovf", 12157, 130, 1, d0);
`endif
    @(negedge clk);
    chk("ovf_sticky_idle", 32'(ovf), 32'd1);

    // clr mid-pass aborts with no done.
    d0 = done_cnt;
    do_start(9);
    beat(12'd2, 2, 0);
    beat(12'd3, 5, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("abort_acc_q", 32'(acc_q), 32'd0);
    chk("abort_acc_idx", 32'(acc_idx), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_w_ready", 32'(w_ready), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'(d0));

    // Clean one-beat pass after the abort.
    d0 = done_cnt;
    do_start(0);
    beat(12'd9, 9, 0);
    end_pass("one_beat", 9, 0, 0, d0);

    // Full-range pass: counter must reach 1023 without wrapping early.
    d0 = done_cnt;
    do_start(1023);
    for (int i = 0; i < 1024; i++) beat(12'd1, i + 1, i);
    end_pass("full", 1024, 1023, 0, d0);

    @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
